regfile_scoreboard: RTL

//   Parametrised register file for the ID stage: NUM_RD async read ports, one write port.

---
 rtl/regfile_scoreboard_if.sv | 32 +++
 rtl/regfile_scoreboard.sv | 66 ++++++
 2 files changed

// File: rtl/regfile_scoreboard_if.sv
// Bundle of the ID-stage register-file signals: read ports, writeback, issue and flush.
// master drives addresses/writeback/issue and consumes data/hazard flags; slave is the register file.
interface regfile_scoreboard_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
);
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD-1:0]        rd_use;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic                     stall;
  logic                     rd_equal;
  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_addr;
  logic [DATA_W-1:0]        wr_data;
  logic                     issue_en;
  logic [ADDR_W-1:0]        issue_addr;
  logic                     sb_clear;

  // No valid/ready pairs here: wr_en, issue_en and sb_clear are single-cycle strobes
  // that are always accepted at the next posedge; reads are combinational with no handshake.
  modport master (
    output rd_addr, rd_use, wr_en, wr_addr, wr_data, issue_en, issue_addr, sb_clear,
    input  rd_data, rd_busy, stall, rd_equal
  );

  modport slave (
    input  rd_addr, rd_use, wr_en, wr_addr, wr_data, issue_en, issue_addr, sb_clear,
    output rd_data, rd_busy, stall, rd_equal
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// ID-stage register file: NUM_RD combinational read ports with write-through bypass,
// one posedge write port, and a per-register busy scoreboard feeding the hazard unit.
module regfile_scoreboard #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input logic                clk,
  input logic                reset_n,
  regfile_scoreboard_if.slave bus
);
  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] r_regs [DEPTH];
  logic [DEPTH-1:0]  r_busy;
  logic [DEPTH-1:0]  w_busy_nxt;
  logic              w_wr_zero;
  logic              w_wr_legal;
  logic              w_wr_live;
  logic              w_issue_legal;

  assign w_wr_zero     = (ZERO_REG != 0) && (bus.wr_addr == '0);
  // Gating on reset_n keeps the bypass from leaking a lost write while reset is held.
  assign w_wr_live     = bus.wr_en & reset_n;
  assign w_wr_legal    = w_wr_live & ~w_wr_zero;
  assign w_issue_legal = bus.issue_en & ~((ZERO_REG != 0) && (bus.issue_addr == '0));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) r_regs[i] <= '0;
    end else if (w_wr_legal) begin
      r_regs[bus.wr_addr] <= bus.wr_data;
    end
  end

  // Flush first, then writeback clears, then issue sets: a new producer beats an old one.
  always_comb begin
    w_busy_nxt = bus.sb_clear ? '0 : r_busy;
    if (bus.wr_en) w_busy_nxt[bus.wr_addr] = 1'b0;
    if (w_issue_legal) w_busy_nxt[bus.issue_addr] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_busy <= '0;
    else          r_busy <= w_busy_nxt;
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] w_addr;
    logic              w_is_zero;
    logic              w_hit;

    assign w_addr    = bus.rd_addr[k*ADDR_W +: ADDR_W];
    assign w_is_zero = (ZERO_REG != 0) && (w_addr == '0);
    assign w_hit     = w_wr_live && (bus.wr_addr == w_addr);

    assign bus.rd_data[k*DATA_W +: DATA_W] = w_is_zero            ? '0 :
                                             (w_hit & w_wr_legal) ? bus.wr_data :
                                                                    r_regs[w_addr];
    assign bus.rd_busy[k] = r_busy[w_addr] & ~w_hit & ~w_is_zero;
  end

  assign bus.stall    = |(bus.rd_use & bus.rd_busy);
  assign bus.rd_equal = (bus.rd_data[0 +: DATA_W] == bus.rd_data[DATA_W +: DATA_W]);
endmodule
